// File: rtl/median_pkg.sv
// Shared types and constants for the 3x3 median window feeder.
// Counter-width helper keeps single-entry dimensions at one bit.
package median_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        SERIAL = 1'b1
    } state_e;

    localparam int WIN_DIM  = 3;
    localparam int WIN_SIZE = WIN_DIM * WIN_DIM;
    localparam int IDX_W    = 4;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/med_line_buf.sv
// One image line of pixel storage: a single address serves both the read
// and the write, and the read returns the value from before this cycle's write.
module med_line_buf
    import median_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = cnt_width(DEPTH)
) (
    input  logic             CLK,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // The window needs the old column value in the same cycle the new pixel
    // lands, so the read is combinational and the write takes effect at the edge.
    assign rd_data = mem[addr];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/median_window.sv
// Raster-stream to 3x3 window serialiser feeding the median core: two line
// buffers plus a window register, nine words per interior pixel position.
module median_window
    import median_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IMG_W = 16,
    parameter int IMG_H = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] DI,
    input  logic             DSI,
    output logic             DRDY,
    output logic [WIDTH-1:0] DO,
    output logic             DSO,
    input  logic             ORDY,
    output logic             LAST,
    output logic             FLAST
);

    localparam int CW = cnt_width(IMG_W);
    localparam int RW = cnt_width(IMG_H);

    localparam logic [0:0] ST_IDLE   = IDLE;
    localparam logic [0:0] ST_SERIAL = SERIAL;

    logic [0:0]       state_reg, state_next;
    logic [CW-1:0]    col_reg, col_next;
    logic [RW-1:0]    row_reg, row_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic             fend_reg, fend_next;

    logic [WIDTH-1:0] win_reg  [WIN_SIZE];
    logic [WIDTH-1:0] win_next [WIN_SIZE];
    logic [WIDTH-1:0] col_in   [WIN_DIM];
    logic [WIDTH-1:0] lb0_rd, lb1_rd;
    logic [WIDTH-1:0] do_mux;

    logic accept, trigger, col_last, row_last, idx_last;

    assign accept   = DSI && (state_reg == ST_IDLE);
    assign col_last = (col_reg == CW'(IMG_W - 1));
    assign row_last = (row_reg == RW'(IMG_H - 1));
    assign idx_last = (idx_reg == IDX_W'(WIN_SIZE - 1));
    assign trigger  = accept && (row_reg >= RW'(2)) && (col_reg >= CW'(2));

    // Line buffers: lb0 holds the previous line, lb1 the one before it.
    med_line_buf #(
        .WIDTH (WIDTH),
        .DEPTH (IMG_W),
        .AW    (CW)
    ) u_lb0 (
        .CLK     (CLK),
        .we      (accept),
        .addr    (col_reg),
        .wr_data (DI),
        .rd_data (lb0_rd)
    );

    med_line_buf #(
        .WIDTH (WIDTH),
        .DEPTH (IMG_W),
        .AW    (CW)
    ) u_lb1 (
        .CLK     (CLK),
        .we      (accept),
        .addr    (col_reg),
        .wr_data (lb0_rd),
        .rd_data (lb1_rd)
    );

    // Incoming right-hand column, top to bottom.
    assign col_in[0] = lb1_rd;
    assign col_in[1] = lb0_rd;
    assign col_in[2] = DI;

    // Window is stored in raster order; each row shifts left by one column.
    generate
        for (genvar gi = 0; gi < WIN_SIZE; gi++) begin : g_win
            if ((gi % WIN_DIM) == (WIN_DIM - 1)) begin : g_edge
                assign win_next[gi] = col_in[gi / WIN_DIM];
            end else begin : g_shift
                assign win_next[gi] = win_reg[gi + 1];
            end
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (accept) begin
            win_reg <= win_next;
        end
    end

    always_comb begin
        col_next = col_reg;
        row_next = row_reg;
        if (accept) begin
            if (col_last) begin
                col_next = '0;
                row_next = row_last ? '0 : row_reg + RW'(1);
            end else begin
                col_next = col_reg + CW'(1);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        fend_next  = fend_reg;
        case (state_reg)
            ST_IDLE: begin
                if (trigger) begin
                    state_next = ST_SERIAL;
                    idx_next   = '0;
                    fend_next  = row_last && col_last;
                end
            end
            ST_SERIAL: begin
                if (ORDY) begin
                    if (idx_last) begin
                        state_next = ST_IDLE;
                    end else begin
                        idx_next = idx_reg + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= ST_IDLE;
            col_reg   <= '0;
            row_reg   <= '0;
            idx_reg   <= '0;
            fend_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            col_reg   <= col_next;
            row_reg   <= row_next;
            idx_reg   <= idx_next;
            fend_reg  <= fend_next;
        end
    end

    always_comb begin
        do_mux = '0;
        for (int i = 0; i < WIN_SIZE; i++) begin
            if (idx_reg == IDX_W'(i)) begin
                do_mux = win_reg[i];
            end
        end
    end

    assign DRDY  = (state_reg == ST_IDLE);
    assign DSO   = (state_reg == ST_SERIAL);
    assign DO    = do_mux;
    assign LAST  = DSO && idx_last;
    assign FLAST = LAST && fend_reg;

endmodule

// File: tb/tb_median_window.sv
// Bench for median_window: three instances (4x4, 5x5, 3x3) driven one at a
// time, a per-cycle scoreboard fed by an image-level window model, plus literal pins.
module tb_median_window;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst   [3] = '{1'b1, 1'b1, 1'b1};
    logic [7:0] di    [3] = '{8'd0, 8'd0, 8'd0};
    logic       dsi   [3] = '{1'b0, 1'b0, 1'b0};
    logic       ordy  [3] = '{1'b1, 1'b1, 1'b1};
    logic       drdy  [3];
    logic [7:0] dout  [3];
    logic       dso   [3];
    logic       last  [3];
    logic       flast [3];

    median_window #(.WIDTH(8), .IMG_W(4), .IMG_H(4)) u_dut4 (
        .CLK(clk), .RST(rst[0]), .DI(di[0]), .DSI(dsi[0]), .DRDY(drdy[0]),
        .DO(dout[0]), .DSO(dso[0]), .ORDY(ordy[0]), .LAST(last[0]), .FLAST(flast[0])
    );
    median_window #(.WIDTH(8), .IMG_W(5), .IMG_H(5)) u_dut5 (
        .CLK(clk), .RST(rst[1]), .DI(di[1]), .DSI(dsi[1]), .DRDY(drdy[1]),
        .DO(dout[1]), .DSO(dso[1]), .ORDY(ordy[1]), .LAST(last[1]), .FLAST(flast[1])
    );
    median_window #(.WIDTH(8), .IMG_W(3), .IMG_H(3)) u_dut3 (
        .CLK(clk), .RST(rst[2]), .DI(di[2]), .DSI(dsi[2]), .DRDY(drdy[2]),
        .DO(dout[2]), .DSO(dso[2]), .ORDY(ordy[2]), .LAST(last[2]), .FLAST(flast[2])
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int         id;
        logic [7:0] v;
        logic       l;
        logic       fl;
    } ent_t;

    ent_t q[$];
    ent_t cap[$];
    ent_t ref0[$];

    int dim[3]     = '{4, 5, 3};
    int mr[3]      = '{0, 0, 0};
    int mc[3]      = '{0, 0, 0};
    int acc_cnt[3] = '{0, 0, 0};
    int img[3][5][5];

    int exp_first[9] = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
    int exp_final[9] = '{6, 7, 8, 10, 11, 12, 14, 15, 16};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Image-level model: store the pixel at its raster position; an interior
    // position yields the 3x3 neighbourhood in raster order.
    function automatic void model_accept(input int d, input logic [7:0] p);
        int r, c, k;
        ent_t e;
        r = mr[d];
        c = mc[d];
        img[d][r][c] = p;
        acc_cnt[d]++;
        if (r >= 2 && c >= 2) begin
            k = 0;
            for (int rr = r - 2; rr <= r; rr++) begin
                for (int cc = c - 2; cc <= c; cc++) begin
                    e.id = d;
                    e.v  = img[d][rr][cc][7:0];
                    e.l  = (k == 8);
                    e.fl = (k == 8) && (r == dim[d] - 1) && (c == dim[d] - 1);
                    q.push_back(e);
                    k++;
                end
            end
        end
        mc[d] = (c == dim[d] - 1) ? 0 : c + 1;
        if (c == dim[d] - 1) begin
            mr[d] = (r == dim[d] - 1) ? 0 : r + 1;
        end
    endfunction

    // Single compare process: outputs of every instance are checked each cycle.
    always @(negedge clk) begin
        ent_t e;
        ent_t a;
        for (int d = 0; d < 3; d++) begin
            if (rst[d]) begin
                mr[d] = 0;
                mc[d] = 0;
                q.delete();
            end else begin
                checks++;
                if (drdy[d] === dso[d]) begin
                    failures++;
                    $display("FAIL drdy_vs_dso dut%0d: drdy=%b dso=%b required drdy=!dso", d, drdy[d], dso[d]);
                end
                if (dso[d] !== 1'b1) begin
                    checks++;
                    if (last[d] !== 1'b0 || flast[d] !== 1'b0) begin
                        failures++;
                        $display("FAIL idle_flags dut%0d: last=%b flast=%b required 0 0", d, last[d], flast[d]);
                    end
                end else if (ordy[d]) begin
                    checks++;
                    a.id = d; a.v = dout[d]; a.l = last[d]; a.fl = flast[d];
                    cap.push_back(a);
                    if (q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_word dut%0d: got do=%0d with no window pending", d, dout[d]);
                    end else begin
                        e = q.pop_front();
                        if (e.id != d || dout[d] !== e.v || last[d] !== e.l || flast[d] !== e.fl) begin
                            failures++;
                            $display("FAIL word dut%0d: got do=%0d last=%b flast=%b expected dut%0d do=%0d last=%b flast=%b",
                                     d, dout[d], last[d], flast[d], e.id, e.v, e.l, e.fl);
                        end
                    end
                end
                if (dsi[d] && drdy[d] === 1'b1) begin
                    model_accept(d, di[d]);
                end
            end
        end
    end

    task automatic send(input int d, input int v);
        int n;
        di[d]  = v[7:0];
        dsi[d] = 1'b1;
        n = 0;
        while (drdy[d] !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL send_timeout dut%0d: drdy=%b required 1 within 200 cycles", d, drdy[d]);
        end
        @(posedge clk); #1;
        dsi[d] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || dso[0] || dso[1] || dso[2]) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 500) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: pending=%0d required 0", q.size());
        end
    endtask

    // mode 0: plain frame, 1: stall ORDY at idx 4 of the first window,
    // 2: reset at idx 5 of the first window and abandon the frame.
    task automatic run_frame(input int d, input int base, input int mode);
        int w;
        w = dim[d];
        for (int r = 0; r < w; r++) begin
            for (int c = 0; c < w; c++) begin
                send(d, base + r * w + c + 1);
                if (r == 2 && c == 2 && mode == 1) begin
                    repeat (4) begin @(posedge clk); #1; end
                    ordy[d] = 1'b0;
                    for (int k = 0; k < 3; k++) begin
                        chk("stall_do", 32'(dout[d]), 32'd6);
                        chk("stall_dso", 32'(dso[d]), 32'd1);
                        chk("stall_drdy", 32'(drdy[d]), 32'd0);
                        @(posedge clk); #1;
                    end
                    ordy[d] = 1'b1;
                end
                if (r == 2 && c == 2 && mode == 2) begin
                    repeat (5) begin @(posedge clk); #1; end
                    chk("rst_pre_do", 32'(dout[d]), 32'd7);
                    rst[d] = 1'b1;
                    @(posedge clk); #1;
                    rst[d] = 1'b0;
                    chk("rst_dso", 32'(dso[d]), 32'd0);
                    chk("rst_drdy", 32'(drdy[d]), 32'd1);
                    return;
                end
            end
        end
    endtask

    initial begin
        int nl, nf, start, n;

        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) rst[d] = 1'b0;
        for (int d = 0; d < 3; d++) begin
            chk("reset_dso", 32'(dso[d]), 32'd0);
            chk("reset_last", 32'(last[d]), 32'd0);
            chk("reset_flast", 32'(flast[d]), 32'd0);
            chk("reset_drdy", 32'(drdy[d]), 32'd1);
        end

        // Plain 4x4 frame.
        cap.delete();
        run_frame(0, 0, 0);
        drain();
        chk("s1_words", cap.size(), 36);
        if (cap.size() == 36) begin
            nl = 0; nf = 0;
            for (int k = 0; k < 9; k++) begin
                chk("s1_first", 32'(cap[k].v), exp_first[k]);
                chk("s1_final", 32'(cap[27 + k].v), exp_final[k]);
            end
            for (int k = 0; k < 36; k++) begin
                nl += int'(cap[k].l);
                nf += int'(cap[k].fl);
            end
            chk("s1_first_last", 32'(cap[8].l), 32'd1);
            chk("s1_final_flast", 32'(cap[35].fl), 32'd1);
            chk("s1_last_count", nl, 4);
            chk("s1_flast_count", nf, 1);
        end
        ref0 = cap;
        $display("scenario plain_frame words=%0d", cap.size());

        // Downstream stall in the first window.
        cap.delete();
        run_frame(0, 0, 1);
        drain();
        chk("s2_words", cap.size(), 36);
        if (cap.size() == 36 && ref0.size() == 36) begin
            for (int k = 0; k < 36; k++) chk("s2_stream", 32'(cap[k].v), 32'(ref0[k].v));
        end
        $display("scenario stall words=%0d", cap.size());

        // Two back-to-back frames, second offset by 100.
        cap.delete();
        run_frame(0, 0, 0);
        run_frame(0, 100, 0);
        drain();
        chk("s3_words", cap.size(), 72);
        if (cap.size() == 72) begin
            for (int k = 0; k < 9; k++) chk("s3_f2_first", 32'(cap[36 + k].v), exp_first[k] + 100);
        end
        $display("scenario two_frames words=%0d", cap.size());

        // Reset mid-window, then resend the frame.
        run_frame(0, 0, 2);
        cap.delete();
        run_frame(0, 0, 0);
        drain();
        chk("s4_words", cap.size(), 36);
        if (cap.size() == 36 && ref0.size() == 36) begin
            for (int k = 0; k < 36; k++) begin
                chk("s4_stream", 32'(cap[k].v), 32'(ref0[k].v));
                chk("s4_flags", {30'd0, cap[k].l, cap[k].fl}, {30'd0, ref0[k].l, ref0[k].fl});
            end
        end
        $display("scenario reset_resend words=%0d", cap.size());

        // 5x5: DSI held high with random pixels and random downstream ready.
        cap.delete();
        start = acc_cnt[1];
        n = 0;
        dsi[1] = 1'b1;
        di[1]  = 8'($urandom);
        while (acc_cnt[1] - start < 25 && n < 2000) begin
            @(posedge clk); #1;
            di[1]   = 8'($urandom);
            ordy[1] = ($urandom_range(0, 3) != 0);
            n++;
        end
        dsi[1]  = 1'b0;
        ordy[1] = 1'b1;
        if (n >= 2000) chk("s5_timeout", n, 0);
        drain();
        nl = 0; nf = 0;
        for (int k = 0; k < cap.size(); k++) begin
            nl += int'(cap[k].l);
            nf += int'(cap[k].fl);
        end
        chk("s5_words", cap.size(), 81);
        chk("s5_windows", nl, 9);
        chk("s5_flast", nf, 1);
        $display("scenario random_5x5 words=%0d cycles=%0d", cap.size(), n);

        // 3x3 border case: only the ninth pixel yields a window.
        cap.delete();
        for (int i = 1; i <= 8; i++) send(2, i);
        chk("s6_quiet_words", cap.size(), 0);
        chk("s6_quiet_dso", 32'(dso[2]), 32'd0);
        send(2, 9);
        drain();
        chk("s6_words", cap.size(), 9);
        if (cap.size() == 9) begin
            for (int k = 0; k < 9; k++) begin
                chk("s6_value", 32'(cap[k].v), k + 1);
                chk("s6_last", 32'(cap[k].l), 32'(k == 8));
                chk("s6_flast", 32'(cap[k].fl), 32'(k == 8));
            end
        end
        $display("scenario border_3x3 words=%0d", cap.size());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "global timeout");
    end

endmodule
